// File: rtl/joy_db15_tx_if.sv
// ---------------------------------------------------------------------------
// joy_db15_tx_if
// Pin-level bundle between the host user port and the DB15 splitter
// emulation. The host side (master) drives the shift clock, the load strobe
// and the button maps. The emulated chain (slave) returns the serial data
// and the frame status.
// ---------------------------------------------------------------------------
interface joy_db15_tx_if;
    logic        joy_clk;     // host shift clock, asynchronous to clk
    logic        joy_load;    // host parallel-load strobe, active-low
    logic [15:0] joystick1;   // player-1 buttons, 1 = pressed, FEDCBAUDLR
    logic [15:0] joystick2;   // player-2 buttons, same encoding
    logic        joy_data;    // serial data to host, active-low
    logic        frame_done;  // one-clk pulse after the 32nd shift
    logic [5:0]  bit_cnt;     // shifts since last load, saturates at 32

    modport master (
        output joy_clk,
        output joy_load,
        output joystick1,
        output joystick2,
        input  joy_data,
        input  frame_done,
        input  bit_cnt
    );

    modport slave (
        input  joy_clk,
        input  joy_load,
        input  joystick1,
        input  joystick2,
        output joy_data,
        output frame_done,
        output bit_cnt
    );
endinterface : joy_db15_tx_if

// File: rtl/joy_db15_tx.sv
// ---------------------------------------------------------------------------
// joy_db15_tx
// Far end of a DB15 joystick splitter: a 32-bit 74HC165-style parallel-in /
// serial-out chain clocked by the host through the user port.
//   * joy_clk / joy_load are brought into the clk domain by SYNC_STAGES flops.
//   * joy_load low loads ~{joystick2, joystick1} every cycle (transparent).
//   * a detected joy_clk rise (load high) shifts right, filling with 1.
//   * joy_data is shreg[0], registered together with the shift register, so
//     a pin edge reaches joy_data SYNC_STAGES+1 clk cycles later.
// Optional feature, macro JOY_DB15_TX_FILTER_EN: each synchronized input is
// followed by a stability filter that only follows the input after FILT_LEN
// consecutive equal samples (latency SYNC_STAGES+FILT_LEN+1).
// ---------------------------------------------------------------------------
module joy_db15_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic          clk,
    input  logic          reset,
    joy_db15_tx_if.slave  bus
);

    // Elaboration-time parameter sanity check.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1) begin : g_param_check
        $error("joy_db15_tx: SYNC_STAGES must be 2..4 and FILT_LEN >= 1");
    end

    // -----------------------------------------------------------------------
    // Synchronizers. Idle values match an idle host: clock low, load high,
    // so leaving reset never looks like an edge or a load.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] load_sync_r;

    // Two-or-more flop synchronizer chains for the asynchronous host pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_r  <= '0;
            load_sync_r <= '1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0],  bus.joy_clk};
            load_sync_r <= {load_sync_r[SYNC_STAGES-2:0], bus.joy_load};
        end
    end

    logic clk_f_s;   // conditioned shift clock level
    logic load_f_s;  // conditioned load level (active-low)

`ifdef JOY_DB15_TX_FILTER_EN
    // -----------------------------------------------------------------------
    // Stability filters: the output flips only after FILT_LEN consecutive
    // samples that disagree with it; any agreeing sample restarts the count,
    // so pulses shorter than FILT_LEN cycles never get through.
    // -----------------------------------------------------------------------
    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_LEN - 1);

    logic           clk_filt_r;
    logic           load_filt_r;
    logic [FCW-1:0] clk_fcnt_r;
    logic [FCW-1:0] load_fcnt_r;

    // Stability filter on the synchronized shift clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_filt_r <= 1'b0;
            clk_fcnt_r <= '0;
        end else if (clk_sync_r[SYNC_STAGES-1] == clk_filt_r) begin
            clk_fcnt_r <= '0;
        end else if (clk_fcnt_r == FCNT_LAST) begin
            clk_filt_r <= clk_sync_r[SYNC_STAGES-1];
            clk_fcnt_r <= '0;
        end else begin
            clk_fcnt_r <= clk_fcnt_r + {{(FCW-1){1'b0}}, 1'b1};
        end
    end

    // Stability filter on the synchronized load strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_filt_r <= 1'b1;
            load_fcnt_r <= '0;
        end else if (load_sync_r[SYNC_STAGES-1] == load_filt_r) begin
            load_fcnt_r <= '0;
        end else if (load_fcnt_r == FCNT_LAST) begin
            load_filt_r <= load_sync_r[SYNC_STAGES-1];
            load_fcnt_r <= '0;
        end else begin
            load_fcnt_r <= load_fcnt_r + {{(FCW-1){1'b0}}, 1'b1};
        end
    end

    assign clk_f_s  = clk_filt_r;
    assign load_f_s = load_filt_r;
`else
    assign clk_f_s  = clk_sync_r[SYNC_STAGES-1];
    assign load_f_s = load_sync_r[SYNC_STAGES-1];
`endif

    // -----------------------------------------------------------------------
    // Edge detection and the shift chain.
    // -----------------------------------------------------------------------
    logic        clk_prev_r;
    logic        rise_s;
    logic [31:0] shreg_r;
    logic [31:0] shreg_n_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_n_s;
    logic        done_n_s;
    logic        joy_data_r;
    logic        frame_done_r;

    assign rise_s = clk_f_s & ~clk_prev_r;

    // Next-state of the chain: load dominates, otherwise shift on a rise.
    always_comb begin
        shreg_n_s = shreg_r;
        cnt_n_s   = cnt_r;
        done_n_s  = 1'b0;
        if (!load_f_s) begin
            shreg_n_s = ~{bus.joystick2, bus.joystick1};
            cnt_n_s   = 6'd0;
        end else if (rise_s) begin
            shreg_n_s = {1'b1, shreg_r[31:1]};
            if (cnt_r == 6'd32) begin
                cnt_n_s = cnt_r;
            end else begin
                cnt_n_s = cnt_r + 6'd1;
            end
            done_n_s = (cnt_r == 6'd31);
        end else begin
            shreg_n_s = shreg_r;
            cnt_n_s   = cnt_r;
        end
    end

    // Chain state and registered outputs; joy_data tracks the new shreg[0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_prev_r   <= 1'b0;
            shreg_r      <= 32'hFFFF_FFFF;
            cnt_r        <= 6'd0;
            joy_data_r   <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            clk_prev_r   <= clk_f_s;
            shreg_r      <= shreg_n_s;
            cnt_r        <= cnt_n_s;
            joy_data_r   <= shreg_n_s[0];
            frame_done_r <= done_n_s;
        end
    end

    assign bus.joy_data   = joy_data_r;
    assign bus.frame_done = frame_done_r;
    assign bus.bit_cnt    = cnt_r;

endmodule : joy_db15_tx

// File: tb/tb_joy_db15_tx.sv
// ---------------------------------------------------------------------------
// tb_joy_db15_tx
// Drives host-side joy_clk / joy_load sequences and compares joy_data,
// bit_cnt and the frame_done count against a frame-level reference model:
// a load captures F = ~{joystick2, joystick1}; after k shifts the wire shows
// F[k] (or 1 once k >= 32), bit_cnt shows min(k, 32), and one frame_done is
// owed each time k reaches 32 from 31.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_joy_db15_tx;

    localparam int SYNC = 2;
    localparam int FILT = 4;
`ifdef JOY_DB15_TX_FILTER_EN
    localparam int LAT  = SYNC + FILT + 1;
    localparam int MINW = FILT + 2;
`else
    localparam int LAT  = SYNC + 1;
    localparam int MINW = 1;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    joy_db15_tx_if bus();

    joy_db15_tx #(
        .SYNC_STAGES (SYNC),
        .FILT_LEN    (FILT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int done_exp  = 0;

    logic [31:0] frame_m;
    int          k_m;

    // Count frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) done_seen = done_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks, landing 2 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic exp_data();
        if (k_m < 32) return frame_m[k_m];
        return 1'b1;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_cnt"},  {26'd0, bus.bit_cnt}, k_m);
        check({tag, "_data"}, {31'd0, bus.joy_data}, {31'd0, exp_data()});
        check({tag, "_done"}, done_seen, done_exp);
    endtask

    task automatic do_load(input logic [15:0] j1, input logic [15:0] j2, input int w);
        bus.joystick1 = j1;
        bus.joystick2 = j2;
        bus.joy_load  = 1'b0;
        tick(w);
        bus.joy_load  = 1'b1;
        frame_m = ~{j2, j1};
        k_m     = 0;
        tick(LAT + 1);
        check_state("load");
    endtask

    task automatic pulse(input int hi, input int lo);
        bus.joy_clk = 1'b1;
        tick(hi);
        bus.joy_clk = 1'b0;
        tick(lo);
        tick(LAT);
        if (k_m == 31) done_exp++;
        if (k_m < 32) k_m++;
        check_state("shift");
    endtask

    int lw;

    initial begin
        bus.joy_clk   = 1'b0;
        bus.joy_load  = 1'b1;
        bus.joystick1 = 16'h0000;
        bus.joystick2 = 16'h0000;
        reset         = 1'b1;
        lw = (MINW > 4) ? MINW : 4;

        // Reset state, then idle after release: no spurious activity.
        tick(3);
        check("rst_data", {31'd0, bus.joy_data},   32'd1);
        check("rst_cnt",  {26'd0, bus.bit_cnt},    32'd0);
        check("rst_done", {31'd0, bus.frame_done}, 32'd0);
        reset = 1'b0;
        frame_m = 32'hFFFF_FFFF;
        k_m     = 0;
        tick(LAT + 4);
        check_state("idle");

        // Single button on player 1 bit 0, full frame.
        do_load(16'h0001, 16'h0000, lw);
        for (int i = 0; i < 32; i++) pulse(8, 8);

        // Player 2 bit 15 last on the wire, then one extra shift.
        do_load(16'h0000, 16'h8000, lw);
        for (int i = 0; i < 33; i++) pulse(8, 8);

        // Abort after 10 shifts with a reload.
        do_load(16'hA5C3, 16'h1234, lw);
        for (int i = 0; i < 10; i++) pulse(8, 8);
        do_load(16'h0003, 16'h0000, lw);
        for (int i = 0; i < 32; i++) pulse(MINW, MINW);

        // Load and clock rise arrive together: load wins, no shift.
        do_load(16'h0F0F, 16'hF0F0, lw);
        for (int i = 0; i < 5; i++) pulse(8, 8);
        bus.joystick1 = 16'h8001;
        bus.joystick2 = 16'h4002;
        bus.joy_load  = 1'b0;
        bus.joy_clk   = 1'b1;
        tick(MINW + 2);
        bus.joy_load  = 1'b1;
        frame_m = ~{16'h4002, 16'h8001};
        k_m     = 0;
        tick(LAT + 2);
        check_state("coinc");
        bus.joy_clk = 1'b0;
        tick(LAT + 2);
        check_state("coinc_low");
        for (int i = 0; i < 32; i++) pulse(MINW, MINW + 1);

        // Asynchronous reset mid-frame at bit 17.
        do_load(16'h0000, 16'h0000, lw);
        for (int i = 0; i < 17; i++) pulse(8, 8);
        #1;
        reset = 1'b1;
        #1;
        check("arst_data", {31'd0, bus.joy_data},   32'd1);
        check("arst_cnt",  {26'd0, bus.bit_cnt},    32'd0);
        check("arst_done", {31'd0, bus.frame_done}, 32'd0);
        tick(3);
        reset = 1'b0;
        frame_m = 32'hFFFF_FFFF;
        k_m     = 0;
        tick(LAT + 2);
        check_state("arst_rel");
        for (int i = 0; i < 3; i++) pulse(8, 8);

`ifdef JOY_DB15_TX_FILTER_EN
        // Short glitch is filtered away; a 6-clk pulse shifts once.
        do_load(16'h00FF, 16'h0000, lw);
        bus.joy_clk = 1'b1;
        tick(2);
        bus.joy_clk = 1'b0;
        tick(LAT + 4);
        check_state("glitch");
        pulse(6, 8);
`endif

        // Randomized frames: random buttons, lengths, aborts and
        // mid-frame joystick changes that must not disturb the frame.
        for (int f = 0; f < 25; f++) begin
            int n;
            do_load(16'($urandom), 16'($urandom), $urandom_range(MINW, MINW + 3));
            n = $urandom_range(0, 36);
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.joystick1 = 16'($urandom);
                    bus.joystick2 = 16'($urandom);
                end
                pulse($urandom_range(MINW, MINW + 5), $urandom_range(MINW, MINW + 5));
            end
        end

        tick(LAT + 2);
        check("final_done", done_seen, done_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_joy_db15_tx

// File: doc/joy_db15_tx.md
JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on joy_clk and joy_load; legal range 2..4.
REQ-002 Parameter FILT_LEN, default 4: number of consecutive equal samples a filtered input needs before it changes; used only when filtering is compiled in.
REQ-003 clk  in  1: single system clock, 40-50 MHz; the only clock in the block.
REQ-004 reset  in  1: asynchronous, active-high reset.
REQ-005 joy_clk  in  1: host shift clock from the user port; asynchronous to clk.
REQ-006 joy_load  in  1: host parallel-load strobe, active-low; asynchronous to clk.
REQ-007 joystick1  in  16: player-1 button map, 1 = pressed, bit order FEDCBAUDLR.
REQ-008 joystick2  in  16: player-2 button map, same encoding as joystick1.
REQ-009 joy_data  out  1: serial data to the host, active-low (0 = pressed).
REQ-010 frame_done  out  1: one-clk pulse when the 32nd bit of a frame has been shifted out.
REQ-011 bit_cnt  out  6: number of shifts since the last load, saturating at 32.

Function
REQ-012 The block emulates the far end of the DB15 splitter: a 32-bit 74HC165-style chain.
REQ-013 joy_clk and joy_load each pass through SYNC_STAGES flops before any use.
REQ-014 A rising edge on joy_clk is detected as synced-now=1 and synced-previous=0.
REQ-015 Load: while synced joy_load=0, every clk cycle sets shreg[31:0] to ~{joystick2,joystick1} and bit_cnt to 0.
- Loading is level-sensitive and transparent; shifting is inhibited during it.
REQ-016 Shift: on a detected joy_clk rise with synced joy_load=1, shreg shifts right by one and bit 31 fills with 1 (serial input tied high).
- bit_cnt increments, saturating at 32.
REQ-017 joy_data is always shreg[0], registered.
- Bit order on the wire: joystick1[0] first, joystick2[15] last.
REQ-018 Latency: joy_data reflects a pin edge SYNC_STAGES+1 clk cycles after it.
REQ-019 frame_done pulses in the cycle bit_cnt goes from 31 to 32, and only then.
REQ-020 Shifts beyond 32 keep bit_cnt at 32, output 1 on joy_data, and raise no further frame_done.
REQ-021 If a load and a clk rise occur in the same cycle, the load wins and no shift happens.
REQ-022 A joy_load falling edge mid-frame discards the remaining bits and reloads; frame_done does not pulse.
REQ-023 Joystick inputs are sampled only during load; changes during shifting do not affect the frame in progress.

Reset
REQ-024 Asserting reset immediately and asynchronously forces all of the following: shreg=32'hFFFF_FFFF, joy_data=1, bit_cnt=0, frame_done=0, all synchronizer and filter flops to idle (joy_clk=0, joy_load=1).
REQ-025 After reset deasserts, the first action is the next load or detected clk rise; no spurious edge may be detected from the idle values.

Configuration
REQ-026 Macro JOY_DB15_TX_FILTER_EN.
- Defined: each synchronized input feeds a stability filter whose output changes only after FILT_LEN consecutive equal samples. Latency becomes SYNC_STAGES+FILT_LEN+1, and pulses shorter than FILT_LEN clk cycles are ignored.
- Undefined: no filter logic is present and the latency is as in REQ-018.

Verification
REQ-027 joystick1=16'h0001, joystick2=0; load low 4 clks then high; 32 joy_clk pulses (8 clk high/8 clk low) -> joy_data=0 for bit 0 only, 1 for bits 1..31; frame_done exactly once after pulse 32.
REQ-028 joystick2=16'h8000; full frame -> joy_data=0 only on bit 31; 33rd pulse -> joy_data=1, bit_cnt stays 32, no frame_done.
REQ-029 Reload after 10 shifts with joystick1=16'h0003 -> bit_cnt=0, joy_data=0; the next frame starts at bit 0 and no frame_done is seen for the aborted frame.
REQ-030 joy_load falls in the same synced cycle as a joy_clk rise -> no shift; shreg equals the newly loaded value.
REQ-031 reset asserted mid-frame at bit 17 -> joy_data=1 and bit_cnt=0 within the same cycle with no clk edge needed; no frame_done after release.
REQ-032 FILTER_EN defined, FILT_LEN=4: a 2-clk joy_clk glitch -> no shift; a 6-clk pulse -> exactly one shift.
